// File: rtl/spi_slave_fifo.sv
// SPI slave with a TX word FIFO, all SPI pins synchronized into clk.
// Define SPI_SLAVE_FIFO_UNDERRUN_EN to enable the sticky underrun_o flag; otherwise underrun_o is tied low.
module spi_slave_fifo #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter bit               CPOL  = 1'b0,
  parameter bit               CPHA  = 1'b0,
  parameter logic [WIDTH-1:0] FILL  = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sck,
  input  logic                     ss,
  input  logic                     mosi,
  output logic                     miso,
  output logic [WIDTH-1:0]         rx_data_o,
  output logic                     rx_valid_o,
  input  logic [WIDTH-1:0]         tx_data_i,
  input  logic                     tx_push_i,
  output logic                     tx_full_o,
  output logic [$clog2(DEPTH):0]   tx_level_o,
  output logic                     abort_o,
  output logic                     busy_o,
  output logic                     underrun_o,
  input  logic                     underrun_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [1:0] sck_sync, ss_sync, mosi_sync;
  logic       sck_q, ss_q;
  logic       sck_s, ss_s, mosi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {2{CPOL}};
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_q     <= CPOL;
      ss_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      ss_sync   <= {ss_sync[0], ss};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_q     <= sck_sync[1];
      ss_q      <= ss_sync[1];
    end
  end

  assign sck_s  = sck_sync[1];
  assign ss_s   = ss_sync[1];
  assign mosi_s = mosi_sync[1];
  assign busy_o = ~ss_s;

  logic ss_fall, ss_rise, lead_edge, trail_edge;
  logic sample_edge, shift_edge, word_done;
  logic [CW-1:0] bit_cnt;

  assign ss_fall     = ss_q & ~ss_s;
  assign ss_rise     = ~ss_q & ss_s;
  assign lead_edge   = ~ss_s & ~ss_fall & (sck_q == CPOL) & (sck_s != CPOL);
  assign trail_edge  = ~ss_s & ~ss_fall & (sck_q != CPOL) & (sck_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign word_done   = sample_edge & (bit_cnt == LAST_BIT);

  // tx_hold: with CPHA=0 a reload is pending for the next shift edge;
  // with CPHA=1 the next leading edge must not shift the freshly loaded word.
  logic             tx_hold;
  logic             tx_load, tx_shift;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] load_word;

  assign tx_load  = ss_fall | (CPHA ? word_done : (shift_edge & tx_hold));
  assign tx_shift = shift_edge & ~tx_hold;
  assign miso     = tx_sh[WIDTH-1];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic             pop, push_ok, underrun_set;

  assign pop          = tx_load & (level != '0);
  assign push_ok      = tx_push_i & ((level != FULL_LVL) | pop);
  assign underrun_set = tx_load & (level == '0);
  assign load_word    = (level != '0) ? mem[rd_ptr] : FILL;
  assign tx_level_o   = level;
  assign tx_full_o    = (level == FULL_LVL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= tx_data_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh   <= '0;
      tx_hold <= 1'b0;
    end else begin
      if (ss_rise)       tx_sh <= '0;
      else if (tx_load)  tx_sh <= load_word;
      else if (tx_shift) tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};

      if (ss_fall)         tx_hold <= CPHA;
      else if (ss_rise)    tx_hold <= 1'b0;
      else if (word_done)  tx_hold <= 1'b1;
      else if (shift_edge) tx_hold <= 1'b0;
    end
  end

  logic [WIDTH-2:0] rx_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh      <= '0;
      bit_cnt    <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      rx_valid_o <= word_done;
      abort_o    <= ss_rise & (bit_cnt != '0);
      if (ss_fall || ss_rise) begin
        rx_sh   <= '0;
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_sh   <= {rx_sh[WIDTH-3:0], mosi_s};
        bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
      end
      if (word_done) rx_data_o <= {rx_sh, mosi_s};
    end
  end

`ifdef SPI_SLAVE_FIFO_UNDERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              underrun_o <= 1'b0;
    else if (underrun_clr_i) underrun_o <= 1'b0;
    else if (underrun_set)   underrun_o <= 1'b1;
  end
`else
  logic unused_underrun;
  assign unused_underrun = underrun_set ^ underrun_clr_i;
  assign underrun_o      = 1'b0;
`endif

endmodule
